// File: rtl/ece178_pio_pkg.sv
// Shared constants for the ece178 second-generation PIO: register map,
// edge-capture selectors and the blink prescaler width.
package ece178_pio_pkg;

  localparam logic [2:0] ADDR_DATA_OUT  = 3'd0;
  localparam logic [2:0] ADDR_DATA_IN   = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd3;
  localparam logic [2:0] ADDR_OUTSET    = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR  = 3'd5;
  localparam logic [2:0] ADDR_OUTTOGGLE = 3'd6;
  localparam logic [2:0] ADDR_BLINK     = 3'd7;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  localparam int BLINK_CNT_W = 32;

  // Next DATA_OUT value for a write at addr; addresses that do not touch
  // DATA_OUT return the current value unchanged.
  function automatic logic [31:0] out_next(input logic [2:0]  addr,
                                           input logic [31:0] cur,
                                           input logic [31:0] wdata);
    case (addr)
      ADDR_DATA_OUT:  return wdata;
      ADDR_OUTSET:    return cur | wdata;
      ADDR_OUTCLEAR:  return cur & ~wdata;
      ADDR_OUTTOGGLE: return cur ^ wdata;
      default:        return cur;
    endcase
  endfunction

endpackage

// File: rtl/ece178_pio_edge_detect.sv
// Input synchroniser chain, previous-sample flop and per-bit edge generation
// for the ece178 PIO input port.
module ece178_pio_edge_detect
  import ece178_pio_pkg::*;
#(
  parameter int IN_WIDTH    = 18,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] in_port,
  output logic [IN_WIDTH-1:0] sync,
  output logic [IN_WIDTH-1:0] edge_det
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("ece178_pio_edge_detect: SYNC_STAGES must be 2..4");
  end
  if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
    $error("ece178_pio_edge_detect: EDGE_TYPE must be 0..2");
  end

  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] chain;
  logic [IN_WIDTH-1:0]                  prev;

  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], in_port};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];

  if (EDGE_TYPE == EDGE_RISING) begin : g_rise
    assign edge_det = sync & ~prev;
  end else if (EDGE_TYPE == EDGE_FALLING) begin : g_fall
    assign edge_det = ~sync & prev;
  end else begin : g_any
    assign edge_det = sync ^ prev;
  end

endmodule

// File: rtl/ece178_pio_gen2.sv
// Avalon-MM PIO slave: output register with set/clear/toggle, synchronised
// input with edge capture and maskable irq. Define ECE178_PIO_BLINK_EN to add
// the BLINK_MASK register and blink prescaler at address 7.
module ece178_pio_gen2
  import ece178_pio_pkg::*;
#(
  parameter int                   OUT_WIDTH   = 18,
  parameter int                   IN_WIDTH    = 18,
  parameter logic [OUT_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                   EDGE_TYPE   = EDGE_RISING,
  parameter int                   SYNC_STAGES = 2,
  parameter int unsigned          BLINK_DIV   = 25000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  if (OUT_WIDTH < 1 || OUT_WIDTH > 32 || IN_WIDTH < 1 || IN_WIDTH > 32) begin : g_bad_width
    $error("ece178_pio_gen2: OUT_WIDTH and IN_WIDTH must be 1..32");
  end

  logic                 wr;
  logic [OUT_WIDTH-1:0] data_out, data_out_d;
  logic [IN_WIDTH-1:0]  irq_mask, edge_cap, edge_cap_d, w1c;
  logic [IN_WIDTH-1:0]  sync, edge_det;
  logic [OUT_WIDTH-1:0] blink_rd;
  logic [31:0]          out_calc;
  logic                 unused_wdata;

  assign wr = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  ece178_pio_edge_detect #(
    .IN_WIDTH   (IN_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .sync    (sync),
    .edge_det(edge_det)
  );

  // NOTE: every always_comb output gets a default first, so no path through
  // the block can leave a value held and infer a latch.
  always_comb begin
    out_calc   = '0;
    data_out_d = data_out;
    w1c        = '0;
    if (wr) begin
      out_calc   = out_next(address, 32'(data_out), writedata);
      data_out_d = out_calc[OUT_WIDTH-1:0];
      if (address == ADDR_EDGE_CAP) w1c = writedata[IN_WIDTH-1:0];
    end
    // A fresh edge wins over a coincident write-1-to-clear.
    edge_cap_d = (edge_cap & ~w1c) | edge_det;
  end

  // NOTE: only control registers live here; there is no memory array, so a
  // full asynchronous reset of every flop costs nothing and is required.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= RESET_VALUE;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      data_out <= data_out_d;
      edge_cap <= edge_cap_d;
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[IN_WIDTH-1:0];
    end
  end

  assign irq = |(edge_cap & irq_mask);

`ifdef ECE178_PIO_BLINK_EN
  localparam logic [BLINK_CNT_W-1:0] BLINK_LAST = BLINK_CNT_W'(BLINK_DIV - 1);

  logic [OUT_WIDTH-1:0]   blink_mask;
  logic [BLINK_CNT_W-1:0] prescale;
  logic                   blink_phase;

  // The prescaler free-runs; writing BLINK_MASK never restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_mask  <= '0;
      prescale    <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (wr && address == ADDR_BLINK) blink_mask <= writedata[OUT_WIDTH-1:0];
      if (prescale == BLINK_LAST) begin
        prescale    <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        prescale <= prescale + 1'b1;
      end
    end
  end

  assign blink_rd = blink_mask;
  assign out_port = data_out ^ (blink_mask & {OUT_WIDTH{blink_phase}});
`else
  assign blink_rd = '0;
  assign out_port = data_out;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA_OUT: readdata[OUT_WIDTH-1:0] = data_out;
      ADDR_DATA_IN:  readdata[IN_WIDTH-1:0]  = sync;
      ADDR_IRQ_MASK: readdata[IN_WIDTH-1:0]  = irq_mask;
      ADDR_EDGE_CAP: readdata[IN_WIDTH-1:0]  = edge_cap;
      ADDR_BLINK:    readdata[OUT_WIDTH-1:0] = blink_rd;
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_ece178_pio_gen2.sv
// Scoreboard bench for ece178_pio_gen2: stimulus pushes expected readdata,
// out_port and irq; a monitor pops and compares on each sample event.
module tb_ece178_pio_gen2;
  import ece178_pio_pkg::*;

  localparam int             OW   = 18;
  localparam int             IW   = 18;
  localparam logic [OW-1:0]  RV   = 18'h2A5A5;
  localparam int             BDIV = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [IW-1:0] in_port;
  logic [OW-1:0] out_port;
  logic          irq;

  ece178_pio_gen2 #(
    .OUT_WIDTH  (OW),
    .IN_WIDTH   (IW),
    .RESET_VALUE(RV),
    .EDGE_TYPE  (EDGE_RISING),
    .SYNC_STAGES(2),
    .BLINK_DIV  (BDIV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .out_port  (out_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [31:0]   rd;
    bit            chk_rd;
    logic [OW-1:0] op;
    bit            chk_op;
    logic          irq;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;
  int   total = 0;
  int   bad   = 0;
  int   tb_edges;

  // Clock edges seen out of reset, used to predict the blink phase.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) tb_edges <= 0;
    else          tb_edges <= tb_edges + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got sample expected queued entry");
      end else begin
        e = sb_q.pop_front();
        if (e.chk_rd) check({e.name, ".readdata"}, readdata, e.rd);
        if (e.chk_op) check({e.name, ".out_port"}, 32'(out_port), 32'(e.op));
        check({e.name, ".irq"}, 32'(irq), 32'(e.irq));
      end
    end
  end

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic sample(input logic [2:0] a, input string n, input logic [31:0] rd,
                        input bit crd, input logic [OW-1:0] op, input bit cop,
                        input logic ir, input bit now);
    exp_t e;
    address  = a;
    e.name   = n;
    e.rd     = rd;
    e.chk_rd = crd;
    e.op     = op;
    e.chk_op = cop;
    e.irq    = ir;
    sb_q.push_back(e);
    if (now) #1;
    else     @(negedge clk);
    -> sample_ev;
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin : stimulus
    logic ph;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = '0;   writedata = '0;    in_port = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state of every address
    sample(ADDR_DATA_OUT, "rst_addr0", 32'h2A5A5, 1, RV, 1, 1'b0, 0);
    for (int a = 1; a < 8; a++)
      sample(3'(a), $sformatf("rst_addr%0d", a), 32'h0, 1, RV, 1, 1'b0, 0);

    // Output register and atomic operations
    bus_write(ADDR_DATA_OUT, 32'h00F0F);
    sample(ADDR_DATA_OUT, "wr_data_out", 32'h00F0F, 1, 18'h00F0F, 1, 1'b0, 0);
    bus_write(ADDR_OUTSET, 32'hFFF30000);
    sample(ADDR_DATA_OUT, "outset", 32'h30F0F, 1, 18'h30F0F, 1, 1'b0, 0);
    bus_write(ADDR_OUTCLEAR, 32'h0000F);
    sample(ADDR_DATA_OUT, "outclear", 32'h30F00, 1, 18'h30F00, 1, 1'b0, 0);
    bus_write(ADDR_OUTTOGGLE, 32'h000FF);
    sample(ADDR_DATA_OUT, "outtoggle", 32'h30FFF, 1, 18'h30FFF, 1, 1'b0, 0);
    sample(ADDR_OUTSET, "outset_reads0", 32'h0, 1, 18'h30FFF, 1, 1'b0, 0);
    bus_write(ADDR_DATA_IN, 32'h3FFFF);
    sample(ADDR_DATA_IN, "data_in_ro", 32'h0, 1, 18'h30FFF, 1, 1'b0, 0);

    // Rising edge on bit 0 through the 2-stage synchroniser
    bus_write(ADDR_IRQ_MASK, 32'h1);
    sample(ADDR_IRQ_MASK, "irq_mask_rd", 32'h1, 1, '0, 0, 1'b0, 0);
    @(posedge clk); #1 in_port[0] = 1'b1;
    sample(ADDR_DATA_IN, "din_pre_e0", 32'h0, 1, '0, 0, 1'b0, 0);
    @(posedge clk); #1;
    sample(ADDR_DATA_IN, "din_after_e0", 32'h0, 1, '0, 0, 1'b0, 0);
    @(posedge clk); #1;
    sample(ADDR_DATA_IN, "din_after_e1", 32'h1, 1, '0, 0, 1'b0, 0);
    @(posedge clk); #1;
    sample(ADDR_EDGE_CAP, "cap_after_e2", 32'h1, 1, '0, 0, 1'b1, 0);
    bus_write(ADDR_EDGE_CAP, 32'h1);
    sample(ADDR_EDGE_CAP, "cap_w1c", 32'h0, 1, '0, 0, 1'b0, 0);

    // Falling edge is ignored in rising mode; re-arm bit 0
    in_port[0] = 1'b0;
    repeat (4) @(posedge clk); #1;
    sample(ADDR_EDGE_CAP, "fall_ignored", 32'h0, 1, '0, 0, 1'b0, 0);
    in_port[0] = 1'b1;
    repeat (3) @(posedge clk); #1;
    sample(ADDR_EDGE_CAP, "cap_rearm", 32'h1, 1, '0, 0, 1'b1, 0);
    in_port[0] = 1'b0;
    repeat (4) @(posedge clk);

    // New edge lands on the same clock as a W1C of that bit: set wins
    #1 in_port[0] = 1'b1;
    @(posedge clk);
    bus_write(ADDR_EDGE_CAP, 32'h1);
    sample(ADDR_EDGE_CAP, "set_wins", 32'h1, 1, '0, 0, 1'b1, 0);
    @(posedge clk); #1;
    sample(ADDR_EDGE_CAP, "set_wins_hold", 32'h1, 1, '0, 0, 1'b1, 0);

    // Mask clear drops irq but keeps the capture
    bus_write(ADDR_IRQ_MASK, 32'h0);
    sample(ADDR_EDGE_CAP, "mask_off", 32'h1, 1, '0, 0, 1'b0, 0);
    bus_write(ADDR_IRQ_MASK, 32'h3);

    // Asynchronous reset with captures pending
    in_port[1] = 1'b1;
    repeat (4) @(posedge clk); #1;
    sample(ADDR_EDGE_CAP, "cap_both", 32'h3, 1, 18'h30FFF, 1, 1'b1, 0);
    @(posedge clk); #2 reset_n = 1'b0;
    sample(ADDR_EDGE_CAP, "async_rst_cap", 32'h0, 1, RV, 1, 1'b0, 1);
    sample(ADDR_DATA_OUT, "async_rst_dout", 32'h2A5A5, 1, RV, 1, 1'b0, 1);
    sample(ADDR_IRQ_MASK, "async_rst_mask", 32'h0, 1, RV, 1, 1'b0, 1);
    @(posedge clk); #1 reset_n = 1'b1;
    sample(ADDR_DATA_IN, "rel_din", 32'h0, 1, RV, 1, 1'b0, 0);
    repeat (3) @(posedge clk); #1;
    sample(ADDR_EDGE_CAP, "rel_high_inputs", 32'h3, 1, RV, 1, 1'b0, 0);

`ifdef ECE178_PIO_BLINK_EN
    bus_write(ADDR_DATA_OUT, 32'h0);
    bus_write(ADDR_BLINK, 32'h1);
    sample(ADDR_BLINK, "blink_mask_rd", 32'h1, 1, '0, 0, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      ph = ((tb_edges / BDIV) % 2) != 0;
      sample(ADDR_DATA_OUT, $sformatf("blink_%0d", i), 32'h0, 1, {17'b0, ph}, 1, 1'b0, 0);
      @(posedge clk); #1;
    end
`else
    bus_write(ADDR_BLINK, 32'h1);
    sample(ADDR_BLINK, "blink_absent", 32'h0, 1, RV, 1, 1'b0, 0);
    ph = 1'b0;
`endif

    #1;
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ece178_pio_gen2.md
Name: ece178_pio_gen2

Overview:
- Parametrised successor to the single-register Avalon-MM output PIO.
- Combines an output port and an input port in one slave.
- Adds atomic set/clear/toggle writes, an input synchroniser, per-bit edge capture and a maskable interrupt.
- Sits on the Nios II Avalon-MM fabric as a zero-wait-state slave driving board LEDs and sampling switches/keys.

Parameters:
- OUT_WIDTH, 18, width of out_port and of the DATA_OUT register (1..32)
- IN_WIDTH, 18, width of in_port and of the capture logic (1..32)
- RESET_VALUE, 0, value loaded into DATA_OUT on reset (OUT_WIDTH bits)
- EDGE_TYPE, 0, capture condition: 0 rising, 1 falling, 2 any edge
- SYNC_STAGES, 2, number of synchroniser flops on in_port (2..4)
- BLINK_DIV, 25000000, clocks per blink half-period (used only with the optional feature)

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  3  Avalon word address
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- readdata  output  32  read data; combinational from address and registers; zero-extended
- in_port  input  IN_WIDTH  asynchronous external inputs
- out_port  output  OUT_WIDTH  external outputs
- irq  output  1  level interrupt, active high

Behaviour:
- Reset is one clock, asynchronous, active-low.
- Write qualifier: wr = chipselect & ~write_n. Writes take effect on the next clk edge. No wait states. Reads have no side effects.
- Address map:
  - 0 DATA_OUT: RW; write loads writedata[OUT_WIDTH-1:0].
  - 1 DATA_IN: RO; returns the synchronised input.
  - 2 IRQ_MASK: RW, IN_WIDTH bits.
  - 3 EDGE_CAP: R; write-1-to-clear per bit.
  - 4 OUTSET: W; DATA_OUT |= wdata.
  - 5 OUTCLEAR: W; DATA_OUT &= ~wdata.
  - 6 OUTTOGGLE: W; DATA_OUT ^= wdata.
  - 7 BLINK: see Optional Feature.
- Reads of addresses 4..6 return 0. Writes to address 1 are ignored.
- Reset values: DATA_OUT = RESET_VALUE; IRQ_MASK = 0; EDGE_CAP = 0; synchroniser and previous-sample flops = 0; irq = 0; out_port = RESET_VALUE.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync. A further flop holds prev.
  - edge = sync & ~prev (rising), ~sync & prev (falling), or sync ^ prev (any).
- Latency: an in_port change set up before clk edge E0 is visible in DATA_IN after edge E0+SYNC_STAGES-1. The EDGE_CAP bit sets at edge E0+SYNC_STAGES. irq asserts in the same cycle as that EDGE_CAP bit if its mask bit is set.
- Reset de-assertion: prev = 0, so input bits already high produce a rising edge once SYNC_STAGES have filled. This is intended behaviour.
- EDGE_CAP next state per bit: (cap & ~(w1c_bit)) | edge. A new edge coincident with a W1C clear leaves the bit set (set wins).
- irq = |(EDGE_CAP & IRQ_MASK). Level, purely from registers, no extra latency. Clearing the mask drops irq the cycle after the write without clearing EDGE_CAP.
- Set/clear/toggle use writedata bits [OUT_WIDTH-1:0]; upper bits are ignored. Single-port slave, so there is no simultaneous-write case.
- Reset asserted mid-operation clears all state immediately, including pending captures and the blink phase.
- Elaboration error if OUT_WIDTH or IN_WIDTH is outside 1..32, SYNC_STAGES is outside 2..4, or EDGE_TYPE > 2.

Optional Feature:
- Macro ECE178_PIO_BLINK_EN.
- When defined:
  - Address 7 is BLINK_MASK (RW, OUT_WIDTH bits, reset 0).
  - A 32-bit prescaler counts 0..BLINK_DIV-1, wraps to 0 and toggles blink_phase (reset 0) on the wrap.
  - out_port = DATA_OUT ^ (BLINK_MASK & {OUT_WIDTH{blink_phase}}).
  - A BLINK_MASK write does not reset the prescaler.
  - DATA_IN and readback of DATA_OUT are unaffected by blinking.
- When undefined: address 7 reads 0, writes are ignored, no prescaler is synthesised, and out_port = DATA_OUT.

Decomposition:
- Package ece178_pio_pkg holds:
  - address localparams ADDR_DATA_OUT..ADDR_BLINK;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY constants;
  - the blink prescaler width constant.
- Sub-module ece178_pio_edge_detect contains the synchroniser chain, the prev flop and edge generation, parametrised by IN_WIDTH, SYNC_STAGES and EDGE_TYPE. It outputs sync and edge.

Test Plan:
- Reset, then read all addresses -> DATA_OUT = RESET_VALUE (set to 0x2A5A5 for this test), all others 0, irq = 0, out_port = 0x2A5A5.
- Write DATA_OUT 0x00F0F, OUTSET 0x30000, OUTCLEAR 0x0000F, OUTTOGGLE 0x000FF -> successive reads 0x00F0F, 0x30F0F, 0x30F00, 0x30FFF; out_port tracks each write one cycle later.
- EDGE_TYPE=0, IRQ_MASK=0x1: drive in_port bit 0 0->1 -> DATA_IN bit 0 = 1 after 1 edge (SYNC_STAGES=2), EDGE_CAP = 0x1 and irq = 1 after 2 edges; write 0x1 to EDGE_CAP -> irq = 0 next cycle.
- Drive a rising edge timed to reach the EDGE_CAP update edge together with a W1C of the same bit -> EDGE_CAP bit stays 1 and irq stays high.
- Assert reset_n low mid-run with EDGE_CAP = 0x3 and irq high -> all registers and irq clear asynchronously without waiting for clk.
- With ECE178_PIO_BLINK_EN and BLINK_DIV=4: DATA_OUT = 0, BLINK_MASK = 0x1 -> out_port bit 0 toggles every 4 clocks; DATA_OUT still reads 0.
